// File: rtl/captura_palabra.sv
`default_nettype none
// ============================================================================
// Module      : captura_palabra
// Description : Front end of the Hamming SECDED path. Synchronises and
//               debounces four data switches and the load pushbutton, then
//               latches a stable 4-bit word once per debounced press.
// Ports       : clk            - system clock, rising edge
//               rst_n          - asynchronous active-low reset
//               conmutador_in  - raw switch levels (asynchronous)
//               boton_cargar   - raw load pushbutton, active-high (asynchronous)
//               palabra        - last captured word, feeds conmutador_4 downstream
//               palabra_valida - one-cycle strobe, palabra updated this cycle
//               ocupado        - high from capture until the debounced release
// Revision    : 1.0 - initial release
// ============================================================================
module captura_palabra #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] conmutador_in,
  input  logic       boton_cargar,
  output logic [3:0] palabra,
  output logic       palabra_valida,
  output logic       ocupado
);

  // Bits [3:0] are the switches, bit [4] is the load button.
  localparam int C_N_IN  = 5;
  localparam int C_CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CAPTURA = 2'd1,
    SOLTAR  = 2'd2
  } estado_t;

  logic [C_N_IN-1:0]  w_raw;
  logic [C_N_IN-1:0]  w_sinc;
  logic [C_N_IN-1:0]  r_sync [SYNC_STAGES];
  logic [C_CNT_W-1:0] r_cnt  [C_N_IN];
  logic [C_N_IN-1:0]  r_estable;
  logic [3:0]         w_sw_estable;
  logic               w_btn_estable;
  logic               r_btn_prev;
  estado_t            r_estado;
  estado_t            w_siguiente;
  logic [3:0]         r_palabra;
  logic               r_valida;
  logic               r_ocupado;

  assign w_raw         = {boton_cargar, conmutador_in};
  assign w_sinc        = r_sync[SYNC_STAGES-1];
  assign w_sw_estable  = r_estable[3:0];
  assign w_btn_estable = r_estable[4];

  // Synchroniser chain, all five inputs in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= w_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Per-input debounce: a new level must be seen on DEBOUNCE_CYCLES
  // consecutive clocks; any return to the old level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_N_IN; i++) begin
        r_cnt[i] <= '0;
      end
      r_estable <= '0;
    end else begin
      for (int i = 0; i < C_N_IN; i++) begin
        if (w_sinc[i] == r_estable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == C_CNT_MAX) begin
          r_estable[i] <= w_sinc[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // State register plus the previous debounced button level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= ESPERA;
      r_btn_prev <= 1'b0;
    end else begin
      r_estado   <= w_siguiente;
      r_btn_prev <= w_btn_estable;
    end
  end

  always_comb begin
    w_siguiente = ESPERA;
    case (r_estado)
      ESPERA:  w_siguiente = (w_btn_estable && !r_btn_prev) ? CAPTURA : ESPERA;
      CAPTURA: w_siguiente = SOLTAR;
      SOLTAR:  w_siguiente = w_btn_estable ? SOLTAR : ESPERA;
      default: w_siguiente = ESPERA;
    endcase
  end

  // Outputs are registered from the next state so the strobe and the new
  // word appear together on the edge that enters CAPTURA. The word sampled
  // is sw_estable as it stood before that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_palabra <= 4'h0;
      r_valida  <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      if (w_siguiente == CAPTURA) begin
        r_palabra <= w_sw_estable;
      end
      r_valida  <= (w_siguiente == CAPTURA);
      r_ocupado <= (w_siguiente != ESPERA);
    end
  end

  assign palabra        = r_palabra;
  assign palabra_valida = r_valida;
  assign ocupado        = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_captura_palabra.sv
`default_nettype none
// ============================================================================
// Module      : tb_captura_palabra
// Description : Self-checking bench for captura_palabra with short debounce.
//               Table of press transactions plus hand-written sequences for
//               reset, latency, switch glitch and reset during a capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_captura_palabra;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] conmutador_in;
  logic       boton_cargar;
  logic [3:0] palabra;
  logic       palabra_valida;
  logic       ocupado;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  captura_palabra #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .conmutador_in  (conmutador_in),
    .boton_cargar   (boton_cargar),
    .palabra        (palabra),
    .palabra_valida (palabra_valida),
    .ocupado        (ocupado)
  );

  typedef struct {
    logic [3:0] sw_pre;
    int         len;
    logic [3:0] sw_mid;
    logic [3:0] exp_pal;
    int         exp_pulses;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " palabra"}, int'(palabra), 0);
    chk({tag, " valida"},  int'(palabra_valida), 0);
    chk({tag, " ocupado"}, int'(ocupado), 0);
  endtask

  // One press transaction: settle switches, press for len clocks (switches
  // optionally changed 10 clocks into the press), release and settle.
  task automatic run_vec(input vec_t v, input int idx);
    int pulses;
    pulses = 0;
    conmutador_in = v.sw_pre;
    repeat (10) tick();
    boton_cargar = 1'b1;
    for (int k = 0; k < v.len; k++) begin
      tick();
      if (palabra_valida) pulses++;
      if (k == 9) conmutador_in = v.sw_mid;
    end
    boton_cargar = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (palabra_valida) pulses++;
    end
    chk($sformatf("vec%0d pulses", idx), pulses, v.exp_pulses);
    chk($sformatf("vec%0d palabra", idx), int'(palabra), int'(v.exp_pal));
    chk($sformatf("vec%0d ocupado", idx), int'(ocupado), 0);
  endtask

  initial begin
    int pulses;
    int first;

    tbl[0] = '{4'hB, 20, 4'hB, 4'hB, 1};  // basic capture
    tbl[1] = '{4'h6,  3, 4'h6, 4'hB, 0};  // button glitch, word unchanged
    tbl[2] = '{4'h6,  4, 4'h6, 4'h6, 1};  // shortest accepted press
    tbl[3] = '{4'h5, 25, 4'hA, 4'h5, 1};  // switches change while held
    tbl[4] = '{4'hA, 20, 4'hA, 4'hA, 1};  // new press picks up the change
    tbl[5] = '{4'h0, 12, 4'hF, 4'h0, 1};  // capture of zero
    tbl[6] = '{4'hF, 12, 4'hF, 4'hF, 1};  // capture of all ones

    // ---------------- reset ----------------
    rst_n         = 1'b1;
    boton_cargar  = 1'b0;
    conmutador_in = 4'h0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset async");
    for (int k = 0; k < 4; k++) begin
      conmutador_in = 4'($urandom_range(0, 15));
      boton_cargar  = ~boton_cargar;
      tick();
    end
    chk_zero("reset held");
    boton_cargar  = 1'b0;
    conmutador_in = 4'h0;
    rst_n         = 1'b1;
    repeat (10) tick();
    chk_zero("after reset");

    // ---------------- table ----------------
    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], i);
    end

    // ---------------- latency and ocupado timing ----------------
    conmutador_in = 4'h7;
    repeat (10) tick();
    boton_cargar = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("latency valida k=%0d", k), int'(palabra_valida), (k == 7) ? 1 : 0);
      if (k == 7) begin
        chk("latency palabra", int'(palabra), 7);
        chk("latency ocupado", int'(ocupado), 1);
      end
    end
    repeat (5) tick();
    boton_cargar = 1'b0;
    repeat (5) tick();
    chk("ocupado after release+5", int'(ocupado), 1);
    repeat (3) tick();
    chk("ocupado after release+8", int'(ocupado), 0);
    repeat (5) tick();

    // ---------------- switch glitch during press ----------------
    conmutador_in = 4'h3;
    repeat (10) tick();
    boton_cargar = 1'b1;
    pulses = 0;
    repeat (2) tick();
    conmutador_in = 4'h2;
    repeat (2) begin
      tick();
      if (palabra_valida) pulses++;
    end
    conmutador_in = 4'h3;
    repeat (20) begin
      tick();
      if (palabra_valida) pulses++;
    end
    boton_cargar = 1'b0;
    repeat (15) begin
      tick();
      if (palabra_valida) pulses++;
    end
    chk("sw glitch pulses", pulses, 1);
    chk("sw glitch palabra", int'(palabra), 3);

    // ---------------- reset during SOLTAR ----------------
    conmutador_in = 4'h9;
    repeat (10) tick();
    boton_cargar = 1'b1;
    repeat (12) tick();
    chk("pre-reset ocupado", int'(ocupado), 1);
    chk("pre-reset palabra", int'(palabra), 9);
    #3 rst_n = 1'b0;
    #1 chk_zero("midop reset async");
    conmutador_in = 4'hC;
    repeat (3) tick();
    chk_zero("midop reset held");
    rst_n  = 1'b1;
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (palabra_valida) begin
        pulses++;
        if (first == 0) begin
          first = k;
          chk("post-reset palabra", int'(palabra), 12);
        end
      end
    end
    chk("post-reset pulses", pulses, 1);
    chk("post-reset latency in 6..8", int'(first >= 6 && first <= 8), 1);
    boton_cargar = 1'b0;
    repeat (15) tick();
    chk("post-reset ocupado", int'(ocupado), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
